axi_core_bus_arbiter: RTL



---
 rtl/ravenoc_pkg.sv | 91 +++++++++
 rtl/axi_core_bus_arbiter_wr_cnt.sv | 47 ++++
 rtl/axi_core_bus_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ravenoc_pkg.sv
// Shared AXI4 types and constants for the RaveNoC tile, plus the enums used by the
// core bus arbiter.
package ravenoc_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 4;

    typedef logic [ID_WIDTH-1:0]   axi_id_t;
    typedef logic [ADDR_WIDTH-1:0] axi_addr_t;
    typedef logic [DATA_WIDTH-1:0] axi_data_t;

    localparam logic [2:0] WORD = 3'b010;
    localparam logic [1:0] INCR = 2'b01;

    typedef struct packed {
        axi_id_t     awid;
        axi_addr_t   awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awlock;
        logic [3:0]  awcache;
        logic [2:0]  awprot;
        logic [3:0]  awqos;
        logic [3:0]  awregion;
        logic        awvalid;
        axi_data_t   wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        bready;
        axi_id_t     arid;
        axi_addr_t   araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arlock;
        logic [3:0]  arcache;
        logic [2:0]  arprot;
        logic [3:0]  arqos;
        logic [3:0]  arregion;
        logic        arvalid;
        logic        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        axi_id_t     bid;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        axi_id_t     rid;
        axi_data_t   rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        rvalid;
    } s_axi_miso_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        IBUS = 2'b01,
        DBUS = 2'b10
    } rd_owner_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_ADDR = 2'b01,
        R_DATA = 2'b10
    } rd_fsm_t;

    // Returns dst with its read-address channel replaced by the one from src.
    function automatic s_axi_mosi_t with_ar_from(s_axi_mosi_t dst, s_axi_mosi_t src);
        s_axi_mosi_t res;
        res          = dst;
        res.arid     = src.arid;
        res.araddr   = src.araddr;
        res.arlen    = src.arlen;
        res.arsize   = src.arsize;
        res.arburst  = src.arburst;
        res.arlock   = src.arlock;
        res.arcache  = src.arcache;
        res.arprot   = src.arprot;
        res.arqos    = src.arqos;
        res.arregion = src.arregion;
        res.arvalid  = src.arvalid;
        return res;
    endfunction

endpackage

// File: rtl/axi_core_bus_arbiter_wr_cnt.sv
// Outstanding D-bus write counter: counts AW handshakes not yet answered on B and
// gates AW once the limit is reached.
module axi_wr_outstanding_cnt #(
    parameter int unsigned MAX_WR_OUT = 4
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       aw_valid,
    input  logic       aw_ready,
    input  logic       b_valid,
    input  logic       b_ready,
    output logic       aw_allow,
    output logic       wr_idle,
    output logic [3:0] wr_pending
);

    logic [3:0] cnt_q, cnt_d;
    logic       aw_hs, b_hs;

    always_comb begin
        aw_allow = (cnt_q != 4'(MAX_WR_OUT));
        wr_idle  = (cnt_q == 4'd0);
        aw_hs    = aw_valid & aw_ready & aw_allow;
        b_hs     = b_valid & b_ready;
        cnt_d    = cnt_q;
        if (aw_hs && !b_hs) begin
            cnt_d = cnt_q + 4'd1;
        end else if (b_hs && !aw_hs && (cnt_q != 4'd0)) begin
            // A stray B at zero is a protocol error; the count is held at zero.
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wr_pending = cnt_q;

    a_no_b_underflow: assert property (@(posedge clk) disable iff (arst)
        !(b_hs && (cnt_q == 4'd0)));

endmodule

// File: rtl/axi_core_bus_arbiter.sv
// Merges the VexRiscv I-bus and D-bus onto one AXI4 master: round-robin single
// outstanding reads, D-bus writes passed through under an outstanding-write limit.
module axi_core_bus_arbiter
    import ravenoc_pkg::*;
#(
    parameter int unsigned MAX_WR_OUT = 4,
    parameter int unsigned IBUS_ID    = 0,
    parameter int unsigned DBUS_ID    = 1
) (
    input  logic        clk,
    input  logic        arst,
    input  s_axi_mosi_t ibus_axi_mosi,
    output s_axi_miso_t ibus_axi_miso,
    input  s_axi_mosi_t dbus_axi_mosi,
    output s_axi_miso_t dbus_axi_miso,
    output s_axi_mosi_t m_axi_mosi,
    input  s_axi_miso_t m_axi_miso,
    output logic [1:0]  rd_owner_o,
    output logic [3:0]  wr_pending_o
);

    localparam axi_id_t IBUS_AXI_ID = axi_id_t'(IBUS_ID);
    localparam axi_id_t DBUS_AXI_ID = axi_id_t'(DBUS_ID);

    rd_fsm_t     rd_state_q, rd_state_d;
    rd_owner_t   owner_q, owner_d;
    rd_owner_t   last_grant_q, last_grant_d;
    s_axi_mosi_t owner_mosi;
    logic        aw_allow;
    logic        wr_idle;
    logic        ibus_req, dbus_req;
    logic        unused_inputs;

    // I-bus write channels and requester IDs are never forwarded.
    assign unused_inputs = ^{ibus_axi_mosi, dbus_axi_mosi.awid, dbus_axi_mosi.arid};

    axi_wr_outstanding_cnt #(
        .MAX_WR_OUT (MAX_WR_OUT)
    ) u_wr_cnt (
        .clk        (clk),
        .arst       (arst),
        .aw_valid   (dbus_axi_mosi.awvalid),
        .aw_ready   (m_axi_miso.awready),
        .b_valid    (m_axi_miso.bvalid),
        .b_ready    (dbus_axi_mosi.bready),
        .aw_allow   (aw_allow),
        .wr_idle    (wr_idle),
        .wr_pending (wr_pending_o)
    );

    assign owner_mosi = (owner_q == DBUS) ? dbus_axi_mosi : ibus_axi_mosi;
    assign rd_owner_o = owner_q;

    always_comb begin
        rd_state_d   = rd_state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        ibus_req     = ibus_axi_mosi.arvalid;
        // D-bus loads wait for earlier stores to complete.
        dbus_req     = dbus_axi_mosi.arvalid & wr_idle;
        unique case (rd_state_q)
            R_IDLE: begin
                if (ibus_req && (!dbus_req || (last_grant_q == DBUS))) begin
                    rd_state_d   = R_ADDR;
                    owner_d      = IBUS;
                    last_grant_d = IBUS;
                end else if (dbus_req) begin
                    rd_state_d   = R_ADDR;
                    owner_d      = DBUS;
                    last_grant_d = DBUS;
                end
            end
            R_ADDR: begin
                if (owner_mosi.arvalid && m_axi_miso.arready) begin
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (m_axi_miso.rvalid && owner_mosi.rready && m_axi_miso.rlast) begin
                    rd_state_d = R_IDLE;
                    owner_d    = NONE;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
                owner_d    = NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rd_state_q   <= R_IDLE;
            owner_q      <= NONE;
            last_grant_q <= DBUS;
        end else begin
            rd_state_q   <= rd_state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        // AW/W/B come straight from the D-bus; the read channels start cleared.
        m_axi_mosi         = with_ar_from(dbus_axi_mosi, '0);
        m_axi_mosi.rready  = 1'b0;
        m_axi_mosi.awid    = DBUS_AXI_ID;
        m_axi_mosi.awvalid = dbus_axi_mosi.awvalid & aw_allow;

        ibus_axi_miso         = '0;
        dbus_axi_miso         = '0;
        dbus_axi_miso.awready = m_axi_miso.awready & aw_allow;
        dbus_axi_miso.wready  = m_axi_miso.wready;
        dbus_axi_miso.bid     = m_axi_miso.bid;
        dbus_axi_miso.bresp   = m_axi_miso.bresp;
        dbus_axi_miso.bvalid  = m_axi_miso.bvalid;

        unique case (rd_state_q)
            R_ADDR: begin
                m_axi_mosi      = with_ar_from(m_axi_mosi, owner_mosi);
                m_axi_mosi.arid = (owner_q == DBUS) ? DBUS_AXI_ID : IBUS_AXI_ID;
                if (owner_q == DBUS) begin
                    dbus_axi_miso.arready = m_axi_miso.arready;
                end else begin
                    ibus_axi_miso.arready = m_axi_miso.arready;
                end
            end
            R_DATA: begin
                m_axi_mosi.rready = owner_mosi.rready;
                if (owner_q == DBUS) begin
                    dbus_axi_miso.rid    = m_axi_miso.rid;
                    dbus_axi_miso.rdata  = m_axi_miso.rdata;
                    dbus_axi_miso.rresp  = m_axi_miso.rresp;
                    dbus_axi_miso.rlast  = m_axi_miso.rlast;
                    dbus_axi_miso.rvalid = m_axi_miso.rvalid;
                end else begin
                    ibus_axi_miso.rid    = m_axi_miso.rid;
                    ibus_axi_miso.rdata  = m_axi_miso.rdata;
                    ibus_axi_miso.rresp  = m_axi_miso.rresp;
                    ibus_axi_miso.rlast  = m_axi_miso.rlast;
                    ibus_axi_miso.rvalid = m_axi_miso.rvalid;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
